fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Owns the architectural PC register and fetches instructions from instruction memory.
- Sits downstream of the next-PC calculation block: it receives taken-branch redirects from that block, issues fetch requests to imem over a valid/ready interface, and presents each fetched instruction plus its PC to decode.
- Holds at most one outstanding imem request and one buffered instruction.

Parameters:
- RESET_PC, 64'd0, PC loaded on reset.
- INST_W, 32, instruction word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redirect_valid  input  1  single-cycle redirect strobe (branch taken).
- redirect_pc  input  64  redirect target, sampled when redirect_valid=1.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  imem accepts request.
- imem_req_addr  output  64  fetch address (= pc).
- imem_rsp_valid  input  1  response strobe, exactly one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  input  INST_W  fetched instruction.
- inst_valid  output  1  buffered instruction valid to decode.
- inst_ready  input  1  decode accepts instruction.
- inst_data  output  INST_W  buffered instruction.
- inst_pc  output  64  PC of buffered instruction.
- fetch_fault  output  1  misaligned-redirect fault (optional feature); tied 0 when the feature is compiled out.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, drop=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0.
- States: IDLE, REQ, WAIT, HOLD. Outputs are decoded from registered state, so there are no comb paths from inputs to outputs.
- IDLE: transitions to REQ unconditionally on the next cycle, so the first request appears one cycle after rst_n deasserts.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid:
  - If drop=1: discard the response, clear drop, go to REQ.
  - Otherwise: inst_data<=imem_rsp_data, inst_pc<=pc, pc<=pc+4, go to HOLD.
- HOLD: inst_valid=1. On inst_ready, go to REQ. Minimum loop is 3 cycles per instruction at zero memory latency.
- PC arithmetic: 64-bit, pc+4 wraps modulo 2^64.
- Redirect has priority over the sequential pc update in every state and sets pc<=redirect_pc.
  - IDLE/REQ without handshake: go to REQ with the new pc.
  - REQ with imem_req_ready in the same cycle: the old-address request was accepted. Go to WAIT with drop=1.
  - WAIT without rsp: drop<=1, stay in WAIT.
  - WAIT with rsp in the same cycle: discard the response, drop<=0, go to REQ.
  - HOLD: the buffer is flushed (inst_valid=0 next cycle), go to REQ. If inst_ready is high in the same cycle, the handshake still completes, so decode has consumed that instruction.
- Back-to-back redirects: the last one wins. drop is a single bit because at most one request is outstanding.
- imem_rsp_valid outside WAIT is a protocol violation and is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset).
  - pc is still updated, and the FSM goes to IDLE and stays there: no further requests, inst_valid=0.
  - A redirect arriving in WAIT still completes the drop of the outstanding response before halting.
- Undefined: no check, fetch_fault tied 0, misaligned addresses are fetched as-is.

Test Plan:
- Reset with RESET_PC=64'h1000, imem_req_ready=1, 1-cycle rsp latency, inst_ready=1 -> requests at 0x1000, 0x1004, 0x1008; inst_pc matches each; first imem_req_valid exactly 1 cycle after rst_n rises.
- inst_ready held 0 for 5 cycles in HOLD -> inst_valid, inst_data, inst_pc stable; no new imem request until the inst_ready handshake.
- Redirect to 0x2000 while in WAIT for 0x1004, rsp arrives 3 cycles later -> response dropped, inst_valid stays 0, next request address is 0x2000, then inst_pc=0x2000.
- Redirect to 0x3000 in HOLD with inst_ready=0 -> inst_valid drops the next cycle, next request is 0x3000; repeat with inst_ready=1 -> the old instruction is counted as consumed once.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next request address is 64'h0.
- With FETCH_ALIGN_CHECK_EN defined, redirect to 0x2002 -> fetch_fault=1 the next cycle, imem_req_valid stays 0 indefinitely; rst_n low clears fetch_fault and refetches RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the architectural PC, issues one imem request at a time and buffers
// one instruction for decode. Define FETCH_ALIGN_CHECK_EN to halt on misaligned redirects.
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [63:0]       inst_pc,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_data_q, inst_data_d;
  logic [63:0]       inst_pc_q, inst_pc_d;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Sticky: once set, only reset clears it.
  always_comb begin
    fault_d = fault_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_req_ready) begin
          state_d = StWait;
          // A redirect racing the handshake leaves a stale request in flight.
          drop_d  = redirect_valid;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_data_d = imem_rsp_data;
            inst_pc_d   = pc_q;
            pc_d        = pc_q + 64'd4;
            state_d     = StHold;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (inst_ready || redirect_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Park in idle instead of issuing anything new; an in-flight drop still completes in WAIT.
    if (fault_d && (state_d == StReq)) begin
      state_d = StIdle;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      inst_data_q <= '0;
      inst_pc_q   <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == StHold);
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;

endmodule
